// File: rtl/inv_revaluate_pkg.sv
// inv_revaluate_pkg
//   Shared decoder definitions: geometry of a state file, the FSM state
//   enumeration, the inverse-chi row table and the forward chi row map.
package inv_revaluate_pkg;

    localparam int unsigned LINES      = 64;
    localparam int unsigned LINE_W     = 25;
    localparam int unsigned FILE_W     = 10;
    localparam int unsigned LINE_IDX_W = $clog2(LINES);
    localparam int unsigned ADDR_W     = FILE_W + LINE_IDX_W;

    localparam logic [LINE_IDX_W-1:0] LAST_LINE = LINE_IDX_W'(LINES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_LATCH,
        ST_WRITE,
        ST_DONE
    } state_t;

    // CHI_INV[b] = a such that chi(a) == b
    localparam logic [4:0] CHI_INV [32] = '{
        5'd0,  5'd11, 5'd22, 5'd9,  5'd13, 5'd4,  5'd18, 5'd15,
        5'd26, 5'd1,  5'd8,  5'd3,  5'd5,  5'd12, 5'd30, 5'd7,
        5'd21, 5'd20, 5'd2,  5'd23, 5'd16, 5'd17, 5'd6,  5'd19,
        5'd10, 5'd27, 5'd24, 5'd25, 5'd29, 5'd28, 5'd14, 5'd31
    };

    // Forward chi on one 5-bit row: b[x] = a[x] ^ (~a[x+1] & a[x+2]), indices mod 5
    function automatic logic [4:0] chi(input logic [4:0] a);
        logic [4:0] rot1;
        logic [4:0] rot2;
        rot1 = {a[0], a[4:1]};
        rot2 = {a[1:0], a[4:2]};
        return a ^ (~rot1 & rot2);
    endfunction

endpackage

// File: rtl/inv_revaluate_if.sv
// inv_revaluate_if
//   Handshake and state-memory bus of the inverse revaluate step.
//   slave  : the inv_revaluate block
//   master : decoder controller plus state memory
//   start/file_index : request to process one file
//   busy/finish      : progress and one-cycle completion pulse
//   mem_addr/mem_rd/rd_data/mem_wr/wr_data : synchronous memory port
interface inv_revaluate_if;
    import inv_revaluate_pkg::*;

    logic              start;
    logic [FILE_W-1:0] file_index;
    logic              busy;
    logic              finish;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [LINE_W-1:0] rd_data;
    logic              mem_wr;
    logic [LINE_W-1:0] wr_data;

    modport slave (
        input  start, file_index, rd_data,
        output busy, finish, mem_addr, mem_rd, mem_wr, wr_data
    );

    modport master (
        output start, file_index, rd_data,
        input  busy, finish, mem_addr, mem_rd, mem_wr, wr_data
    );

endinterface

// File: rtl/inv_revaluate_inv_chi_row.sv
// inv_chi_row
//   Combinational inverse of chi for one 5-bit row, by table lookup.
//   i_row : chi output row
//   o_row : row that chi maps onto i_row
module inv_chi_row
    import inv_revaluate_pkg::*;
(
    input  logic [4:0] i_row,
    output logic [4:0] o_row
);

    assign o_row = CHI_INV[i_row];

endmodule

// File: rtl/inv_revaluate.sv
// inv_revaluate
//   Applies inverse chi to all 64 lines of one state file in place.
//   Each line takes three cycles: READ (strobe), LATCH (transform the
//   returned word), WRITE (store it back at the same address).
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : inv_revaluate_if.slave (start/file_index/busy/finish + memory port)
module inv_revaluate
    import inv_revaluate_pkg::*;
(
    input logic            clk,
    input logic            rst,
    inv_revaluate_if.slave bus
);

    state_t                r_state;
    logic [LINE_IDX_W-1:0] r_line;
    logic [FILE_W-1:0]     r_file;
    logic                  r_busy;
    logic                  r_finish;
    logic                  r_rd;
    logic                  r_wr;
    logic [LINE_W-1:0]     r_wr_data;
    logic [LINE_W-1:0]     w_inv;

    // Five rows inverted in parallel from the word returned by memory
    for (genvar y = 0; y < 5; y++) begin : g_row
        inv_chi_row u_row (
            .i_row (bus.rd_data[5*y +: 5]),
            .o_row (w_inv[5*y +: 5])
        );
    end

    // Strobes and busy/finish are set on the transition into their state,
    // so every output comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_line    <= '0;
            r_file    <= '0;
            r_busy    <= 1'b0;
            r_finish  <= 1'b0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_wr_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_file  <= bus.file_index;
                        r_line  <= '0;
                        r_busy  <= 1'b1;
                        r_rd    <= 1'b1;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_rd    <= 1'b0;
                    r_state <= ST_LATCH;
                end
                ST_LATCH: begin
                    r_wr_data <= w_inv;
                    r_wr      <= 1'b1;
                    r_state   <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_wr <= 1'b0;
                    if (r_line == LAST_LINE) begin
                        r_busy   <= 1'b0;
                        r_finish <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_line  <= r_line + 1'b1;
                        r_rd    <= 1'b1;
                        r_state <= ST_READ;
                    end
                end
                ST_DONE: begin
                    r_finish <= 1'b0;
                    r_line   <= '0;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.finish   = r_finish;
    assign bus.mem_addr = {r_file, r_line};
    assign bus.mem_rd   = r_rd;
    assign bus.mem_wr   = r_wr;
    assign bus.wr_data  = r_wr_data;

endmodule

// File: tb/tb_inv_revaluate.sv
`timescale 1ns/1ps
module tb_inv_revaluate;
    import inv_revaluate_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inv_revaluate_if bus();

    inv_revaluate dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [4:0] lut_in;
    logic [4:0] lut_out;
    inv_chi_row u_lut (
        .i_row (lut_in),
        .o_row (lut_out)
    );

    // Behavioural synchronous memory plus bus monitor
    logic [LINE_W-1:0] mem [65536];
    logic              ld_en;
    logic [15:0]       ld_addr;
    logic [LINE_W-1:0] ld_data;
    logic [FILE_W-1:0] exp_file;
    int cyc_abs   = 0;
    int wr_count  = 0;
    int wr_bad    = 0;
    int overlap   = 0;
    int fin_count = 0;

    always @(posedge clk) begin
        cyc_abs++;
        if (bus.mem_rd && bus.mem_wr) overlap++;
        if (bus.mem_rd) bus.rd_data <= mem[bus.mem_addr];
        if (bus.mem_wr) begin
            wr_count++;
            if (bus.mem_addr[15:6] !== exp_file) wr_bad++;
            mem[bus.mem_addr] = bus.wr_data;
        end
        if (ld_en) mem[ld_addr] = ld_data;
        if (bus.finish) fin_count++;
    end

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int fin_abs = 0;

    logic [LINE_W-1:0] snap  [64];
    logic [LINE_W-1:0] orig0 [64];
    logic [LINE_W-1:0] orig1 [64];

    // ---------------- reference model ----------------
    function automatic logic [4:0] inv_row(input logic [4:0] v);
        logic [4:0] r = '0;
        for (int a = 0; a < 32; a++)
            if (chi(5'(a)) == v) r = 5'(a);
        return r;
    endfunction

    function automatic logic [LINE_W-1:0] inv_line(input logic [LINE_W-1:0] l);
        logic [LINE_W-1:0] r = '0;
        for (int y = 0; y < 5; y++)
            r |= LINE_W'(inv_row(5'(l >> (5*y)))) << (5*y);
        return r;
    endfunction

    function automatic logic [LINE_W-1:0] chi_line(input logic [LINE_W-1:0] l);
        logic [LINE_W-1:0] r = '0;
        for (int y = 0; y < 5; y++)
            r |= LINE_W'(chi(5'(l >> (5*y)))) << (5*y);
        return r;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"},    32'(bus.busy),     32'd0);
        chk({tag, "_finish"},  32'(bus.finish),   32'd0);
        chk({tag, "_mem_rd"},  32'(bus.mem_rd),   32'd0);
        chk({tag, "_mem_wr"},  32'(bus.mem_wr),   32'd0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_wr_data"}, 32'(bus.wr_data),  32'd0);
    endtask

    task automatic load(input logic [15:0] a, input logic [LINE_W-1:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic fill_random(input logic [FILE_W-1:0] f);
        for (int i = 0; i < 64; i++) load({f, 6'(i)}, LINE_W'($urandom));
    endtask

    task automatic take_snap(input logic [FILE_W-1:0] f);
        for (int i = 0; i < 64; i++) snap[i] = mem[{f, 6'(i)}];
    endtask

    // lines 0..last_done should hold inv(snap), the rest untouched
    task automatic check_file(input string tag, input logic [FILE_W-1:0] f, input int last_done);
        for (int i = 0; i < 64; i++) begin
            logic [LINE_W-1:0] e;
            e = (i <= last_done) ? inv_line(snap[i]) : snap[i];
            chk(tag, 32'(mem[{f, 6'(i)}]), 32'(e));
        end
    endtask

    task automatic start_pulse(input logic [FILE_W-1:0] f);
        bus.start = 1'b1; bus.file_index = f;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Called at cycle 1 after the accepting edge. Returns the relative
    // finish cycle (-1 if none within the bound or if reset was injected).
    task automatic monitor_run(input int rst_cyc, input int inj_cyc, input logic [FILE_W-1:0] inj_file,
                               output int fin, output int bfirst, output int blast, output int bcnt);
        bit done = 1'b0;
        fin = -1; bfirst = -1; blast = -1; bcnt = 0;
        for (int c = 1; c <= 400 && !done; c++) begin
            if (c == rst_cyc) begin
                rst = 1'b1; #1;
                chk_reset("midrun_reset");
                done = 1'b1;
            end else begin
                if (c == inj_cyc) begin
                    bus.start = 1'b1; bus.file_index = inj_file;
                end else if (c == inj_cyc + 1) begin
                    bus.start = 1'b0;
                end
                if (bus.busy) begin
                    bcnt++;
                    if (bfirst < 0) bfirst = c;
                    blast = c;
                end
                if (bus.finish) begin
                    fin = c; fin_abs = cyc_abs; done = 1'b1;
                end else begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    // ---------------- stimulus ----------------
    int fin, bf, bl, bc, w0, b0, f0, fa1;

    initial begin
        bus.start = 1'b0; bus.file_index = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        exp_file = '0;
        lut_in = '0;
        rst = 1'b1;
        #1;
        chk_reset("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Inverse row table against forward chi, every value
        for (int v = 0; v < 32; v++) begin
            lut_in = 5'(v); #1;
            chk("lut_roundtrip", 32'(chi(lut_out)), 32'(v));
        end
        lut_in = 5'd0; #1;
        chk("lut_zero", 32'(lut_out), 32'd0);
        @(posedge clk); #1;

        // Single file, timing and contents
        fill_random(10'd3);
        take_snap(10'd3);
        exp_file = 10'd3;
        w0 = wr_count; b0 = wr_bad; f0 = fin_count;
        start_pulse(10'd3);
        monitor_run(-1, -1, '0, fin, bf, bl, bc);
        chk("f3_finish_cycle", 32'(fin), 32'd193);
        chk("f3_busy_first", 32'(bf), 32'd1);
        chk("f3_busy_last", 32'(bl), 32'd192);
        chk("f3_busy_count", 32'(bc), 32'd192);
        @(posedge clk); #1;
        chk("f3_finish_low", 32'(bus.finish), 32'd0);
        chk("f3_writes", 32'(wr_count - w0), 32'd64);
        chk("f3_bad_addr", 32'(wr_bad - b0), 32'd0);
        chk("f3_finishes", 32'(fin_count - f0), 32'd1);
        check_file("f3_line", 10'd3, 63);
        for (int i = 0; i < 64; i++)
            chk("f3_chi_restores", 32'(chi_line(mem[{10'd3, 6'(i)}])), 32'(snap[i]));

        // Start while busy is ignored
        fill_random(10'd2);
        take_snap(10'd2);
        exp_file = 10'd2;
        w0 = wr_count; b0 = wr_bad; f0 = fin_count;
        start_pulse(10'd2);
        monitor_run(-1, 50, 10'd5, fin, bf, bl, bc);
        chk("ign_finish_cycle", 32'(fin), 32'd193);
        @(posedge clk); #1;
        chk("ign_writes", 32'(wr_count - w0), 32'd64);
        chk("ign_bad_addr", 32'(wr_bad - b0), 32'd0);
        chk("ign_finishes", 32'(fin_count - f0), 32'd1);
        check_file("ign_line", 10'd2, 63);

        // Reset in the middle of a run
        fill_random(10'd4);
        take_snap(10'd4);
        exp_file = 10'd4;
        w0 = wr_count;
        start_pulse(10'd4);
        monitor_run(100, -1, '0, fin, bf, bl, bc);
        @(posedge clk); #1;
        chk_reset("held_reset");
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_writes", 32'(wr_count - w0), 32'd33);
        check_file("rst_line", 10'd4, 32);
        take_snap(10'd4);
        w0 = wr_count;
        start_pulse(10'd4);
        monitor_run(-1, -1, '0, fin, bf, bl, bc);
        chk("rst_fresh_finish", 32'(fin), 32'd193);
        @(posedge clk); #1;
        chk("rst_fresh_writes", 32'(wr_count - w0), 32'd64);
        check_file("rst_fresh_line", 10'd4, 63);

        // Round trip through the encoder map, files 0 and 1023 back to back
        for (int i = 0; i < 64; i++) begin
            orig0[i] = LINE_W'($urandom);
            orig1[i] = LINE_W'($urandom);
            load({10'd0, 6'(i)}, chi_line(orig0[i]));
            load({10'd1023, 6'(i)}, chi_line(orig1[i]));
        end
        exp_file = 10'd0;
        w0 = wr_count; b0 = wr_bad; f0 = fin_count;
        start_pulse(10'd0);
        monitor_run(-1, -1, '0, fin, bf, bl, bc);
        chk("rt0_finish_cycle", 32'(fin), 32'd193);
        fa1 = fin_abs;
        // start held through the finish cycle and the following one
        exp_file = 10'd1023;
        bus.start = 1'b1; bus.file_index = 10'd1023;
        @(posedge clk); #1;
        chk("b2b_not_in_done", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        monitor_run(-1, -1, '0, fin, bf, bl, bc);
        chk("b2b_finish_gap", 32'(fin_abs - fa1), 32'd194);
        @(posedge clk); #1;
        chk("rt_writes", 32'(wr_count - w0), 32'd128);
        chk("rt_bad_addr", 32'(wr_bad - b0), 32'd0);
        chk("rt_finishes", 32'(fin_count - f0), 32'd2);
        for (int i = 0; i < 64; i++) begin
            chk("rt0_line", 32'(mem[{10'd0, 6'(i)}]), 32'(orig0[i]));
            chk("rt1023_line", 32'(mem[{10'd1023, 6'(i)}]), 32'(orig1[i]));
        end

        chk("rd_wr_exclusive", 32'(overlap), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
